// File: rtl/dmem_bus_ctrl.sv
// Data-memory bus controller: turns a core load/store request into one bus cycle
// on a DAD/DDT bus with ACKD_n handshake, lane steering, extension and a wait timeout.
module dmem_bus_ctrl #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        sgn,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        done,
    output logic        err,
    output logic [31:0] DAD,
    output logic        MREQ,
    output logic        WRITE,
    output logic [1:0]  SIZE,
    output logic [31:0] DDT_out,
    output logic        DDT_oe,
    input  logic [31:0] DDT_in,
    input  logic        ACKD_n
);

    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } state_e;

    state_e state_q, state_d;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      addr_q, addr_d;
    logic             we_q, we_d;
    logic [1:0]       size_q, size_d;
    logic             sgn_q, sgn_d;
    logic [31:0]      lanes_q, lanes_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             mreq_q, mreq_d;
    logic             write_q, write_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic        misaligned;
    logic        accept;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_data;
    logic [31:0] store_lanes;

    assign misaligned = ((size == 2'b01) && addr[0])
                     || ((size == 2'b10) && (addr[1:0] != 2'b00))
                     ||  (size == 2'b11);

    assign accept = (state_q == IDLE) && req && !misaligned;

    // Stores place the same data on every lane the addressed unit may use.
    always_comb begin
        case (size)
            2'b00:   store_lanes = {4{wdata[7:0]}};
            2'b01:   store_lanes = {2{wdata[15:0]}};
            default: store_lanes = wdata;
        endcase
    end

    always_comb begin
        case (addr_q[1:0])
            2'd0:    byte_sel = DDT_in[7:0];
            2'd1:    byte_sel = DDT_in[15:8];
            2'd2:    byte_sel = DDT_in[23:16];
            default: byte_sel = DDT_in[31:24];
        endcase
        half_sel = addr_q[1] ? DDT_in[31:16] : DDT_in[15:0];
    end

    always_comb begin
        case (size_q)
            2'b00:   load_data = sgn_q ? {{24{byte_sel[7]}}, byte_sel}
                                       : {24'd0, byte_sel};
            2'b01:   load_data = sgn_q ? {{16{half_sel[15]}}, half_sel}
                                       : {16'd0, half_sel};
            default: load_data = DDT_in;
        endcase
    end

    // NOTE: state and all registers update with non-blocking assignments so every
    // flop samples pre-edge values; reset is synchronous and overrides everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every combinational output gets a default before the case so no path
    // leaves a signal unassigned and infers a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    state_d = misaligned ? ERR : BUS;
                end
            end
            BUS: begin
                if (!ACKD_n) begin
                    state_d = DONE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ERR;
                end
            end
            DONE:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Bus-facing and handshake outputs are computed from the next state and
    // registered, so they change exactly with the state they belong to.
    always_comb begin
        addr_d  = addr_q;
        we_d    = we_q;
        size_d  = size_q;
        sgn_d   = sgn_q;
        lanes_d = lanes_q;
        rdata_d = rdata_q;
        cnt_d   = '0;

        if (accept) begin
            addr_d  = addr;
            we_d    = we;
            size_d  = size;
            sgn_d   = sgn;
            lanes_d = store_lanes;
        end

        if ((state_q == BUS) && (state_d == BUS)) begin
            cnt_d = cnt_q + 1'b1;
        end

        if ((state_q == BUS) && !ACKD_n && !we_q) begin
            rdata_d = load_data;
        end

        mreq_d  = (state_d == BUS);
        write_d = (state_d == BUS) && we_d;
        done_d  = (state_d == DONE) || (state_d == ERR);
        err_d   = (state_d == ERR);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            sgn_q   <= 1'b0;
            lanes_q <= '0;
            rdata_q <= '0;
            mreq_q  <= 1'b0;
            write_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            size_q  <= size_d;
            sgn_q   <= sgn_d;
            lanes_q <= lanes_d;
            rdata_q <= rdata_d;
            mreq_q  <= mreq_d;
            write_q <= write_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign stall   = (state_q == BUS) || ((state_q == IDLE) && req);
    assign rdata   = rdata_q;
    assign done    = done_q;
    assign err     = err_q;
    assign DAD     = addr_q;
    assign MREQ    = mreq_q;
    assign WRITE   = write_q;
    assign SIZE    = size_q;
    assign DDT_out = lanes_q;
    assign DDT_oe  = write_q;

endmodule

// File: tb/tb_dmem_bus_ctrl.sv
// Directed bench for dmem_bus_ctrl: inputs change and outputs are checked on the
// falling edge; all expected values are hand-computed constants.
module tb_dmem_bus_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [1:0]  size = 2'b00;
    logic        sgn = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        stall;
    logic        done;
    logic        err;
    logic [31:0] DAD;
    logic        MREQ;
    logic        WRITE;
    logic [1:0]  SIZE;
    logic [31:0] DDT_out;
    logic        DDT_oe;
    logic [31:0] DDT_in = '0;
    logic        ACKD_n = 1'b1;

    int n_cmp = 0;
    int n_bad = 0;

    dmem_bus_ctrl #(.TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .size(size), .sgn(sgn),
        .addr(addr), .wdata(wdata), .rdata(rdata), .stall(stall), .done(done),
        .err(err), .DAD(DAD), .MREQ(MREQ), .WRITE(WRITE), .SIZE(SIZE),
        .DDT_out(DDT_out), .DDT_oe(DDT_oe), .DDT_in(DDT_in), .ACKD_n(ACKD_n)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag, input logic [31:0] exp_rdata);
        check({tag, "_rdata"}, rdata, exp_rdata);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_err"}, 32'(err), 32'd0);
        check({tag, "_mreq"}, 32'(MREQ), 32'd0);
        check({tag, "_write"}, 32'(WRITE), 32'd0);
        check({tag, "_oe"}, 32'(DDT_oe), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int mreq_cycles;
        bit seen_done;

        // Reset values
        @(negedge clk);
        check_idle_outputs("rst", 32'h0);
        check("rst_dad", DAD, 32'h0);
        check("rst_size", 32'(SIZE), 32'd0);
        check("rst_ddt_out", DDT_out, 32'h0);
        check("rst_stall", 32'(stall), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Signed byte load from the top lane, acknowledged immediately
        @(negedge clk);
        req = 1'b1; we = 1'b0; size = 2'b00; sgn = 1'b1; addr = 32'h0000_0103;
        #1 check("lb_idle_stall", 32'(stall), 32'd1);
        @(negedge clk);
        check("lb_mreq", 32'(MREQ), 32'd1);
        check("lb_dad", DAD, 32'h0000_0103);
        check("lb_size", 32'(SIZE), 32'd0);
        check("lb_write", 32'(WRITE), 32'd0);
        check("lb_oe", 32'(DDT_oe), 32'd0);
        check("lb_bus_done", 32'(done), 32'd0);
        check("lb_bus_stall", 32'(stall), 32'd1);
        ACKD_n = 1'b0; DDT_in = 32'h80FF_1234;
        addr = 32'hFFFF_FFFF; size = 2'b10; sgn = 1'b0;
        @(negedge clk);
        check("lb_done", 32'(done), 32'd1);
        check("lb_err", 32'(err), 32'd0);
        check("lb_done_mreq", 32'(MREQ), 32'd0);
        check("lb_rdata", rdata, 32'hFFFF_FF80);
        check("lb_done_stall", 32'(stall), 32'd0);
        req = 1'b0; ACKD_n = 1'b1; DDT_in = 32'h0;
        @(negedge clk);
        check_idle_outputs("lb_after", 32'hFFFF_FF80);

        // Half store with three wait cycles
        req = 1'b1; we = 1'b1; size = 2'b01; sgn = 1'b0;
        addr = 32'h0000_0202; wdata = 32'h0000_BEEF;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("sh_mreq%0d", i), 32'(MREQ), 32'd1);
            check($sformatf("sh_write%0d", i), 32'(WRITE), 32'd1);
            check($sformatf("sh_oe%0d", i), 32'(DDT_oe), 32'd1);
            check($sformatf("sh_stall%0d", i), 32'(stall), 32'd1);
            check($sformatf("sh_done%0d", i), 32'(done), 32'd0);
            if (i == 0) begin
                check("sh_ddt_out", DDT_out, 32'hBEEF_BEEF);
                check("sh_dad", DAD, 32'h0000_0202);
                check("sh_size", 32'(SIZE), 32'd1);
                wdata = 32'h1234_5678;
            end
            if (i == 3) ACKD_n = 1'b0;
        end
        @(negedge clk);
        check("sh_done", 32'(done), 32'd1);
        check("sh_err", 32'(err), 32'd0);
        check("sh_done_mreq", 32'(MREQ), 32'd0);
        check("sh_done_oe", 32'(DDT_oe), 32'd0);
        check("sh_rdata_kept", rdata, 32'hFFFF_FF80);
        req = 1'b0; ACKD_n = 1'b1; we = 1'b0;

        // Misaligned word load: no bus cycle, error next cycle
        @(negedge clk);
        req = 1'b1; size = 2'b10; addr = 32'h0000_0201;
        @(negedge clk);
        check("mis_mreq", 32'(MREQ), 32'd0);
        check("mis_done", 32'(done), 32'd1);
        check("mis_err", 32'(err), 32'd1);
        check("mis_rdata", rdata, 32'hFFFF_FF80);
        check("mis_stall", 32'(stall), 32'd0);
        req = 1'b0;
        @(negedge clk);
        check_idle_outputs("mis_after", 32'hFFFF_FF80);

        // Word load that never gets acknowledged
        req = 1'b1; size = 2'b10; addr = 32'h0000_0300; ACKD_n = 1'b1;
        mreq_cycles = 0;
        seen_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) begin
                seen_done = 1'b1;
                break;
            end
            if (MREQ) mreq_cycles++;
        end
        check("to_seen_done", 32'(seen_done), 32'd1);
        check("to_mreq_cycles", 32'(mreq_cycles), 32'd16);
        check("to_err", 32'(err), 32'd1);
        check("to_mreq", 32'(MREQ), 32'd0);
        check("to_rdata", rdata, 32'hFFFF_FF80);
        req = 1'b0;
        @(negedge clk);
        check_idle_outputs("to_after", 32'hFFFF_FF80);

        // Reset during the second wait cycle aborts the access
        req = 1'b1; size = 2'b10; addr = 32'h0000_0400; ACKD_n = 1'b1;
        @(negedge clk);
        check("ab_mreq", 32'(MREQ), 32'd1);
        @(negedge clk);
        check("ab_mreq2", 32'(MREQ), 32'd1);
        rst = 1'b1; req = 1'b0;
        @(negedge clk);
        check_idle_outputs("ab_rst", 32'h0);
        check("ab_dad", DAD, 32'h0);
        check("ab_ddt_out", DDT_out, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        check("ab_no_done", 32'(done), 32'd0);

        // Unsigned half load from the upper half after reset
        req = 1'b1; we = 1'b0; size = 2'b01; sgn = 1'b0; addr = 32'h0000_0002;
        ACKD_n = 1'b0; DDT_in = 32'h8001_0000;
        @(negedge clk);
        check("lh_mreq", 32'(MREQ), 32'd1);
        check("lh_size", 32'(SIZE), 32'd1);
        @(negedge clk);
        check("lh_done", 32'(done), 32'd1);
        check("lh_err", 32'(err), 32'd0);
        check("lh_rdata", rdata, 32'h0000_8001);
        req = 1'b0; ACKD_n = 1'b1;
        @(negedge clk);
        check_idle_outputs("lh_after", 32'h0000_8001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dmem_bus_ctrl.md
DMEM_BUS_CTRL -- requirements
Module: dmem_bus_ctrl

Interface
REQ-001 SHALL have a single clock; reset is synchronous and active-high.
REQ-002 SHALL have parameter TIMEOUT, default 16, meaning ACKD_n wait-cycle limit before a bus error.
REQ-003 SHALL have ports: clk input 1, rising-edge clock; rst input 1, synchronous active-high reset.
REQ-004 SHALL have ports: req input 1, core load/store request (level, held until done); we input 1, 1 = store.
REQ-005 SHALL have ports: size input 2, 00 byte / 01 half / 10 word / 11 illegal; sgn input 1, 1 = sign-extend load.
REQ-006 SHALL have ports: addr input 32, byte address; wdata input 32, store data (right-aligned).
REQ-007 SHALL have ports: rdata output 32, extended load data; stall output 1, hold core; done output 1, access complete; err output 1, access failed.
REQ-008 SHALL have ports: DAD output 32, bus address; MREQ output 1; WRITE output 1; SIZE output 2; DDT_out output 32; DDT_oe output 1, tristate enable.
REQ-009 SHALL have ports: DDT_in input 32, bus read data; ACKD_n input 1, active-low bus acknowledge.

Function
REQ-010 SHALL implement FSM states IDLE, BUS, DONE, ERR.
REQ-011 SHALL in IDLE with req=1 and aligned access latch addr, we, size, sgn, wdata and go to BUS next cycle.
REQ-012 SHALL treat as misaligned: size=01 with addr[0]=1; size=10 with addr[1:0]!=0; size=11 any address.
REQ-013 SHALL in IDLE with req=1 and misaligned access go to ERR without any bus cycle (MREQ stays 0).
REQ-014 SHALL in BUS drive MREQ=1, DAD=latched addr, SIZE=latched size, WRITE=latched we, DDT_oe=latched we; all registered outputs.
REQ-015 SHALL replicate store data across lanes: byte -> {4{wdata[7:0]}}, half -> {2{wdata[15:0]}}, word -> wdata.
REQ-016 SHALL sample ACKD_n each BUS cycle; ACKD_n=0 ends the access, captures DDT_in (loads), and moves to DONE.
REQ-017 SHALL extract load lanes little-endian: byte = DDT_in[8*addr[1:0]+:8], half = DDT_in[16*addr[1]+:16], word = DDT_in.
REQ-018 SHALL zero- or sign-extend byte/half per latched sgn; stores leave rdata unchanged.
REQ-019 SHALL count BUS cycles with ACKD_n=1; reaching TIMEOUT moves to ERR and deasserts MREQ.
REQ-020 SHALL in DONE assert done=1 one cycle, err=0, MREQ=0, DDT_oe=0, then return to IDLE.
REQ-021 SHALL in ERR assert done=1 and err=1 one cycle, rdata unchanged, then return to IDLE.
REQ-022 SHALL drive stall=1 in BUS and in IDLE when req=1 (combinational); stall=0 in DONE and ERR.
REQ-023 SHALL not accept a new req in DONE/ERR; the next access starts from IDLE at earliest one cycle after done.
REQ-024 SHALL hold rdata stable from DONE until the next load completes.
REQ-025 SHALL give latency: req in IDLE cycle N with ACKD_n=0 first BUS cycle -> BUS N+1, done N+2; each wait cycle adds one.
REQ-026 SHALL ignore changes on addr/wdata/size/we/sgn after latching in IDLE.

Reset
REQ-027 SHALL on rst=1 at a clock edge enter IDLE, clear timeout counter, and drive rdata=0, done=0, err=0, MREQ=0, WRITE=0, DDT_oe=0, DAD=0, SIZE=0, DDT_out=0.
REQ-028 SHALL abort an in-progress BUS access on rst immediately (MREQ=0 next cycle), with no done pulse.

Verification
REQ-029 Load byte signed, addr=0x103, DDT_in=0x80FF_1234, ACKD_n=0 at once -> MREQ high 1 cycle, SIZE=00, done at N+2, rdata=0xFFFF_FF80.
REQ-030 Store half, addr=0x202, wdata=0x0000_BEEF, ACKD_n low after 3 waits -> DDT_out=0xBEEF_BEEF, WRITE=1, DDT_oe=1, stall high 4 BUS cycles, done at N+5.
REQ-031 Load word addr=0x201 -> no MREQ, done=1 and err=1 at N+1, rdata unchanged.
REQ-032 Load word, ACKD_n held high -> MREQ drops after 16 BUS cycles, done=1 and err=1 one cycle.
REQ-033 rst asserted during 2nd BUS wait cycle -> all outputs at reset values next cycle, no done; subsequent load half unsigned addr=0x2, DDT_in=0x8001_0000 -> rdata=0x0000_8001.
